// File: rtl/tcam_controller.sv
// tcam_controller: shares one TCAM port between updates and lookups, tracks entry valid bits,
// and returns lookup results in order through a credit-protected response FIFO.
module tcam_controller #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic              upd_invalidate,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_key,
    input  logic [DATA_W-1:0] upd_mask,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [DATA_W-1:0] lk_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_addr,
    input  logic              flush,
    output logic              busy,
    output logic [DATA_W-1:0] tcam_data,
    output logic              tcam_write_readN,
    output logic [DATA_W-1:0] tcam_dontcare_mask,
    output logic [ADDR_W-1:0] tcam_write_address,
    input  logic [ADDR_W-1:0] tcam_found_address,
    input  logic              tcam_hit
);
    localparam int ENTRIES = 2 ** ADDR_W;
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

    state_t              state;
    logic [ENTRIES-1:0]  valid;
    logic                last_lk, p1, p2;
    logic [CW-1:0]       count;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [ADDR_W:0]     fifo_mem [RSP_DEPTH];
    logic                open, lk_ok, grant_u, grant_l, pop, cap_hit;

    // a lookup needs a guaranteed FIFO slot, counting everything still in the match pipeline
    assign open      = state == RUN && !flush && !reset;
    assign lk_ok     = (32'(count) + 32'(p1) + 32'(p2)) < 32'(RSP_DEPTH);
    assign upd_ready = open && !(lk_valid && lk_ok && !last_lk);
    assign lk_ready  = open && lk_ok && !(upd_valid && last_lk);
    assign grant_u   = upd_valid && upd_ready;
    assign grant_l   = lk_valid && lk_ready;
    assign rsp_valid = count != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign cap_hit   = tcam_hit && valid[tcam_found_address];
    assign {rsp_hit, rsp_addr} = fifo_mem[rd_ptr];
    assign busy      = state != RUN || p1 || p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= RUN;
            valid              <= '0;
            last_lk            <= 1'b1;
            p1                 <= 1'b0;
            p2                 <= 1'b0;
            count              <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            tcam_data          <= '0;
            tcam_write_readN   <= 1'b0;
            tcam_dontcare_mask <= '0;
            tcam_write_address <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            p1               <= grant_l;
            p2               <= p1;
            tcam_write_readN <= grant_u && !upd_invalidate;
            if (grant_u) last_lk <= 1'b0;
            else if (grant_l) last_lk <= 1'b1;
            if (grant_u && !upd_invalidate) begin
                tcam_data          <= upd_key;
                tcam_dontcare_mask <= upd_mask;
                tcam_write_address <= upd_addr;
            end else if (grant_l) begin
                tcam_data          <= lk_key;
                tcam_dontcare_mask <= '0;
            end
            if (grant_u) valid[upd_addr] <= !upd_invalidate;
            if (state == FLUSH) valid <= '0;
            state <= state == RUN ? (flush ? DRAIN : RUN) : state == DRAIN ? ((p1 || p2) ? DRAIN : FLUSH) : RUN;
            if (p2) begin
                fifo_mem[wr_ptr] <= {cap_hit, cap_hit ? tcam_found_address : ADDR_W'(0)};
                wr_ptr           <= wr_ptr == PW'(RSP_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr == PW'(RSP_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(p2) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_tcam_controller.sv
// tb_tcam_controller: table vectors, directed corner sequences and randomized traffic against
// an entry-level reference model, with a behavioural TCAM attached to the controller.
module tb_tcam_controller;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          upd_valid = 1'b0, upd_invalidate = 1'b0;
    logic          upd_ready;
    logic [AW-1:0] upd_addr = '0;
    logic [DW-1:0] upd_key = '0, upd_mask = '0;
    logic          lk_valid = 1'b0;
    logic          lk_ready;
    logic [DW-1:0] lk_key = '0;
    logic          rsp_valid, rsp_hit;
    logic          rsp_ready = 1'b1;
    logic [AW-1:0] rsp_addr;
    logic          flush = 1'b0;
    logic          busy;
    logic [DW-1:0] tcam_data, tcam_dontcare_mask;
    logic          tcam_write_readN;
    logic [AW-1:0] tcam_write_address;
    logic [AW-1:0] tcam_found_address = '0;
    logic          tcam_hit = 1'b0;

    int total = 0;
    int bad = 0;

    tcam_controller dut (
        .clk(clk), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_invalidate(upd_invalidate),
        .upd_addr(upd_addr), .upd_key(upd_key), .upd_mask(upd_mask),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
        .flush(flush), .busy(busy),
        .tcam_data(tcam_data), .tcam_write_readN(tcam_write_readN),
        .tcam_dontcare_mask(tcam_dontcare_mask), .tcam_write_address(tcam_write_address),
        .tcam_found_address(tcam_found_address), .tcam_hit(tcam_hit)
    );

    always #5 clk = ~clk;

    // behavioural TCAM: registered match, lowest address wins, contents survive controller reset
    logic [DW-1:0] t_key [16];
    logic [DW-1:0] t_mask [16];
    bit            t_wr [16];
    always @(posedge clk) begin
        bit f;
        logic [AW-1:0] fa;
        f = 1'b0;
        fa = '0;
        for (int i = 15; i >= 0; i--)
            if (t_wr[i] && ((tcam_data ^ t_key[i]) & ~t_mask[i]) == '0) begin
                f = 1'b1;
                fa = AW'(i);
            end
        tcam_hit <= f;
        tcam_found_address <= fa;
        if (tcam_write_readN) begin
            t_key[tcam_write_address]  <= tcam_data;
            t_mask[tcam_write_address] <= tcam_dontcare_mask;
            t_wr[tcam_write_address]   <= 1'b1;
        end
    end

    // reference model: entry contents and valid bits as seen by requests in grant order
    logic [DW-1:0] m_key [16];
    logic [DW-1:0] m_mask [16];
    bit            m_wr [16];
    bit            m_valid [16];
    logic [AW:0]   exp_q [$];
    logic [AW:0]   got_q [$];

    function automatic logic [AW:0] ref_lookup(input logic [DW-1:0] k);
        for (int i = 0; i < 16; i++)
            if (m_wr[i] && ((k ^ m_key[i]) & ~m_mask[i]) == '0)
                return m_valid[i] ? {1'b1, AW'(i)} : '0;
        return '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (upd_valid && upd_ready) begin
                if (upd_invalidate) m_valid[upd_addr] = 1'b0;
                else begin
                    m_key[upd_addr]   = upd_key;
                    m_mask[upd_addr]  = upd_mask;
                    m_wr[upd_addr]    = 1'b1;
                    m_valid[upd_addr] = 1'b1;
                end
            end
            if (lk_valid && lk_ready) exp_q.push_back(ref_lookup(lk_key));
            if (rsp_valid && rsp_ready) begin
                got_q.push_back({rsp_hit, rsp_addr});
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got response %0h, required none", {rsp_hit, rsp_addr});
                end else chk("rsp_model", 32'({rsp_hit, rsp_addr}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input bit inv, input logic [AW-1:0] a, input logic [DW-1:0] k, input logic [DW-1:0] m);
        int n = 0;
        upd_valid = 1'b1; upd_invalidate = inv; upd_addr = a; upd_key = k; upd_mask = m;
        #1;
        while (!upd_ready && n < 50) begin tick; #1; n++; end
        if (!upd_ready) begin
            total++; bad++;
            $display("FAIL upd_accept: upd_ready stuck at 0, required 1");
            upd_valid = 1'b0;
            return;
        end
        tick;
        upd_valid = 1'b0;
        chk("wr_strobe", 32'(tcam_write_readN), 32'(!inv));
        if (!inv) begin
            chk("wr_addr", 32'(tcam_write_address), 32'(a));
            chk("wr_data", 32'(tcam_data), 32'(k));
            chk("wr_mask", 32'(tcam_dontcare_mask), 32'(m));
        end
    endtask

    task automatic do_lk(input logic [DW-1:0] k);
        int n = 0;
        lk_valid = 1'b1; lk_key = k;
        #1;
        while (!lk_ready && n < 50) begin tick; #1; n++; end
        if (!lk_ready) begin
            total++; bad++;
            $display("FAIL lk_accept: lk_ready stuck at 0, required 1");
            lk_valid = 1'b0;
            return;
        end
        tick;
        lk_valid = 1'b0;
    endtask

    task automatic lk_expect(input string name, input logic [DW-1:0] k, input bit eh, input logic [AW-1:0] ea);
        int n = 0;
        logic [AW:0] r;
        got_q.delete();
        do_lk(k);
        while (got_q.size() == 0 && n < 30) begin tick; n++; end
        if (got_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: no response, required one", name);
            return;
        end
        r = got_q.pop_front();
        chk({name, "_hit"}, 32'(r[AW]), 32'(eh));
        chk({name, "_addr"}, 32'(r[AW-1:0]), 32'(ea));
    endtask

    task automatic wait_drain;
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin tick; n++; end
        if (n == 200) begin
            total++; bad++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    function automatic logic [DW-1:0] rnd_key();
        logic [DW-1:0] b;
        case ($urandom_range(0, 3))
            0: b = 16'h1200;
            1: b = 16'h12A0;
            2: b = 16'hAB00;
            default: b = 16'h5550;
        endcase
        return b | DW'($urandom_range(0, 15));
    endfunction

    function automatic logic [DW-1:0] rnd_mask();
        case ($urandom_range(0, 3))
            0: return 16'h0000;
            1: return 16'h000F;
            2: return 16'h00FF;
            default: return 16'hF000;
        endcase
    endfunction

    typedef struct packed {
        bit            upd;
        bit            inv;
        logic [AW-1:0] addr;
        logic [DW-1:0] key;
        logic [DW-1:0] mask;
        bit            hit;
        logic [AW-1:0] eaddr;
    } vec_t;

    vec_t          tbl [14];
    logic [DW-1:0] ks [6];

    initial begin
        int ug, lg, idx, n;
        bit alt_ok, prev_u, u, l;
        tbl[0]  = '{1'b1, 1'b0, 4'd3, 16'h12A0, 16'h000F, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b0, 4'd0, 16'h12A7, 16'h0000, 1'b1, 4'd3};
        tbl[2]  = '{1'b0, 1'b0, 4'd0, 16'h13A7, 16'h0000, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 1'b0, 4'd7, 16'h5555, 16'h0000, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 1'b0, 4'd0, 16'h5555, 16'h0000, 1'b1, 4'd7};
        tbl[5]  = '{1'b1, 1'b0, 4'd2, 16'h5550, 16'h000F, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 1'b0, 4'd0, 16'h5555, 16'h0000, 1'b1, 4'd2};
        tbl[7]  = '{1'b1, 1'b1, 4'd2, 16'h0000, 16'h0000, 1'b0, 4'd0};
        tbl[8]  = '{1'b0, 1'b0, 4'd0, 16'h5555, 16'h0000, 1'b0, 4'd0};
        tbl[9]  = '{1'b1, 1'b1, 4'd3, 16'h0000, 16'h0000, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 1'b0, 4'd0, 16'h12A7, 16'h0000, 1'b0, 4'd0};
        tbl[11] = '{1'b1, 1'b0, 4'd3, 16'h12A0, 16'h000F, 1'b0, 4'd0};
        tbl[12] = '{1'b0, 1'b0, 4'd0, 16'h12AF, 16'h0000, 1'b1, 4'd3};
        tbl[13] = '{1'b0, 1'b0, 4'd0, 16'hFFFF, 16'h0000, 1'b0, 4'd0};
        ks = '{16'h12A7, 16'h5555, 16'hF00A, 16'h0000, 16'h12A1, 16'hF00D};

        upd_valid = 1'b1; lk_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_upd_ready", 32'(upd_ready), 0);
        chk("rst_lk_ready", 32'(lk_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_strobe", 32'(tcam_write_readN), 0);
        chk("rst_tcam_data", 32'(tcam_data), 0);
        chk("rst_tcam_mask", 32'(tcam_dontcare_mask), 0);
        chk("rst_tcam_addr", 32'(tcam_write_address), 0);
        upd_valid = 1'b0; lk_valid = 1'b0; reset = 1'b0;
        tick;

        lk_valid = 1'b1; lk_key = 16'h0000;
        #1;
        chk("lat_accept", 32'(lk_ready), 1);
        tick;
        lk_valid = 1'b0;
        chk("lat_n1_valid", 32'(rsp_valid), 0);
        chk("lat_n1_search", 32'(tcam_write_readN), 0);
        tick;
        chk("lat_n2_valid", 32'(rsp_valid), 0);
        chk("lat_n2_busy", 32'(busy), 1);
        tick;
        chk("lat_n3_valid", 32'(rsp_valid), 1);
        chk("lat_n3_hit", 32'(rsp_hit), 0);
        chk("lat_n3_addr", 32'(rsp_addr), 0);
        tick;
        chk("lat_n4_popped", 32'(rsp_valid), 0);

        for (int i = 0; i < 14; i++)
            if (tbl[i].upd) do_upd(tbl[i].inv, tbl[i].addr, tbl[i].key, tbl[i].mask);
            else lk_expect($sformatf("vec%0d", i), tbl[i].key, tbl[i].hit, tbl[i].eaddr);

        lk_key = 16'h12A7; upd_invalidate = 1'b0; upd_mask = '0; upd_addr = 4'd10; upd_key = 16'hF00A;
        upd_valid = 1'b1; lk_valid = 1'b1; ug = 0; lg = 0; alt_ok = 1'b1; prev_u = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            u = upd_ready; l = lk_ready;
            ug += int'(u); lg += int'(l);
            if (u == l || (c > 0 && u == prev_u)) alt_ok = 1'b0;
            prev_u = u;
            tick;
            if (u) begin upd_addr = upd_addr + 1'b1; upd_key = upd_key + 1'b1; end
        end
        upd_valid = 1'b0; lk_valid = 1'b0;
        chk("rr_upd_grants", 32'(ug), 4);
        chk("rr_lk_grants", 32'(lg), 4);
        chk("rr_alternate", 32'(alt_ok), 1);
        wait_drain;
        lk_expect("rr_written", 16'hF00B, 1'b1, 4'd11);

        rsp_ready = 1'b0; got_q.delete(); idx = 0;
        for (int c = 0; c < 10; c++) begin
            lk_valid = 1'b1; lk_key = ks[idx];
            #1;
            if (lk_ready) idx++;
            tick;
        end
        lk_key = ks[idx];
        #1;
        chk("credit_accepted", 32'(idx), 4);
        chk("credit_stall", 32'(lk_ready), 0);
        chk("credit_full_valid", 32'(rsp_valid), 1);
        rsp_ready = 1'b1; n = 0;
        while (idx < 6 && n < 30) begin
            lk_key = ks[idx];
            #1;
            if (lk_ready) idx++;
            tick;
            n++;
        end
        lk_valid = 1'b0;
        wait_drain;
        chk("credit_total", 32'(idx), 6);
        chk("credit_rsp_count", 32'(got_q.size()), 6);

        got_q.delete();
        do_upd(1'b0, 4'd5, 16'hABCD, 16'h0000);
        lk_valid = 1'b1; lk_key = 16'hABCD;
        #1;
        chk("fl_lk_accept", 32'(lk_ready), 1);
        tick;
        lk_valid = 1'b0; flush = 1'b1; upd_valid = 1'b1; upd_addr = 4'd6; upd_key = 16'h1111; upd_mask = '0;
        #1;
        chk("fl_upd_block", 32'(upd_ready), 0);
        chk("fl_busy0", 32'(busy), 1);
        tick;
        lk_valid = 1'b1;
        #1;
        chk("fl_drain_lk_block", 32'(lk_ready), 0);
        chk("fl_drain_upd_block", 32'(upd_ready), 0);
        chk("fl_busy1", 32'(busy), 1);
        tick;
        flush = 1'b0; lk_valid = 1'b0; upd_valid = 1'b0;
        chk("fl_busy2", 32'(busy), 1);
        tick;
        chk("fl_busy3", 32'(busy), 1);
        tick;
        chk("fl_busy_done", 32'(busy), 0);
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        chk("fl_inflight_count", 32'(got_q.size()), 1);
        if (got_q.size() > 0) chk("fl_inflight_rsp", 32'(got_q.pop_front()), 32'({1'b1, 4'd5}));
        lk_expect("post_flush_a", 16'hABCD, 1'b0, 4'd0);
        lk_expect("post_flush_b", 16'h12A7, 1'b0, 4'd0);

        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 12; j++) begin
                if ($urandom_range(0, 3) == 0) tick;
                do_upd($urandom_range(0, 3) == 0, AW'($urandom_range(0, 15)), rnd_key(), rnd_mask());
            end
            for (int j = 0; j < 25; j++) begin
                lk_key = rnd_key();
                lk_valid = $urandom_range(0, 3) != 0;
                rsp_ready = $urandom_range(0, 2) != 0;
                tick;
            end
            lk_valid = 1'b0; rsp_ready = 1'b1;
            wait_drain;
        end

        do_upd(1'b0, 4'd3, 16'h12A0, 16'h000F);
        rsp_ready = 1'b0;
        do_lk(16'h12A7);
        do_lk(16'h12A7);
        tick; tick; tick;
        chk("rst_mid_buffered", 32'(rsp_valid), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_lk_ready", 32'(lk_ready), 0);
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        tick;
        reset = 1'b0; rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk("rst_mid_quiet", 32'(rsp_valid), 0);
        end
        chk("rst_mid_no_rsp", 32'(got_q.size()), 0);
        lk_expect("post_reset", 16'h12A7, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
